// File: rtl/mem_wb_hilo_pkg.sv
// mem_wb_hilo_pkg: shared widths, constants and stall indices for the MEM/WB stage
package mem_wb_hilo_pkg;
  localparam int RegBus = 32;
  localparam int RegAddrBus = 5;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  localparam logic WriteEnable = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic RstEnable = 1'b0;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB = 5;
endpackage

// File: rtl/mem_wb_hilo_hilo_reg.sv
// hilo_reg: architectural HI/LO pair, written together on we
module hilo_reg
  import mem_wb_hilo_pkg::*;
#(
  parameter int DW = RegBus
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);
  logic [DW-1:0] hi_q, lo_q;
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      hi_q <= DW'(ZeroWord);
      lo_q <= DW'(ZeroWord);
    end else if (we) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end
  assign hi_o = hi_q;
  assign lo_o = lo_q;
endmodule

// File: rtl/mem_wb_hilo.sv
// mem_wb_hilo: MEM/WB pipeline register with HI/LO commit and newest-value bypass to EX
module mem_wb_hilo
  import mem_wb_hilo_pkg::*;
#(
  parameter int DW = RegBus,
  parameter int AW = RegAddrBus
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall,
  input  logic          flush,
  input  logic [AW-1:0] mem_wd,
  input  logic          mem_wreg,
  input  logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_hi,
  input  logic [DW-1:0] mem_lo,
  input  logic          mem_whilo,
  output logic [AW-1:0] wb_wd,
  output logic          wb_wreg,
  output logic [DW-1:0] wb_wdata,
  output logic [DW-1:0] wb_hi,
  output logic [DW-1:0] wb_lo,
  output logic          wb_whilo,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);
  logic [AW-1:0] wd_d, wd_q;
  logic [DW-1:0] wdata_d, wdata_q, hi_d, hi_q, lo_d, lo_q;
  logic          wreg_d, wreg_q, whilo_d, whilo_q;
  logic          bubble, hold, commit;
  logic [DW-1:0] arch_hi, arch_lo;
  logic          unused_stall;
  assign unused_stall = ^stall[3:0];
  // A stalled WB also covers the illegal MEM-running/WB-stalled case as a hold.
  always_comb begin
    bubble  = flush | (stall[STALL_MEM] & ~stall[STALL_WB]);
    hold    = stall[STALL_WB];
    wd_d    = bubble ? AW'(NOPRegAddr) : hold ? wd_q : mem_wd;
    wreg_d  = bubble ? WriteDisable : hold ? wreg_q : mem_wreg;
    wdata_d = bubble ? DW'(ZeroWord) : hold ? wdata_q : mem_wdata;
    hi_d    = bubble ? DW'(ZeroWord) : hold ? hi_q : mem_hi;
    lo_d    = bubble ? DW'(ZeroWord) : hold ? lo_q : mem_lo;
    whilo_d = bubble ? WriteDisable : hold ? whilo_q : mem_whilo;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wd_q    <= AW'(NOPRegAddr);
      wreg_q  <= WriteDisable;
      wdata_q <= DW'(ZeroWord);
      hi_q    <= DW'(ZeroWord);
      lo_q    <= DW'(ZeroWord);
      whilo_q <= WriteDisable;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
    end
  end
  // Flush does not cancel a commit already sitting in WB; only a WB stall does.
  assign commit = (whilo_q == WriteEnable) & ~stall[STALL_WB];
  hilo_reg #(.DW(DW)) u_hilo (
    .clk (clk),
    .rst (rst),
    .we  (commit),
    .hi_i(hi_q),
    .lo_i(lo_q),
    .hi_o(arch_hi),
    .lo_o(arch_lo)
  );
  assign hi_o     = mem_whilo ? mem_hi : whilo_q ? hi_q : arch_hi;
  assign lo_o     = mem_whilo ? mem_lo : whilo_q ? lo_q : arch_lo;
  assign wb_wd    = wd_q;
  assign wb_wreg  = wreg_q;
  assign wb_wdata = wdata_q;
  assign wb_hi    = hi_q;
  assign wb_lo    = lo_q;
  assign wb_whilo = whilo_q;
  a_stall_order: assert property (@(posedge clk) disable iff (!rst)
    !(stall[STALL_WB] && !stall[STALL_MEM]));
endmodule

// File: tb/tb_mem_wb_hilo.sv
// tb_mem_wb_hilo: directed and random checks of mem_wb_hilo against a pipeline model
module tb_mem_wb_hilo;
  localparam int DW = 32;
  localparam int AW = 5;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [5:0]    stall = '0;
  logic          flush = 1'b0;
  logic [AW-1:0] mem_wd = '0;
  logic          mem_wreg = 1'b0;
  logic [DW-1:0] mem_wdata = '0, mem_hi = '0, mem_lo = '0;
  logic          mem_whilo = 1'b0;
  logic [AW-1:0] wb_wd;
  logic          wb_wreg, wb_whilo;
  logic [DW-1:0] wb_wdata, wb_hi, wb_lo, hi_o, lo_o;
  typedef struct {
    logic [AW-1:0] wd;
    logic          wreg;
    logic [DW-1:0] wdata;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          whilo;
  } wb_t;
  wb_t           m;
  logic [DW-1:0] a_hi, a_lo;
  int            n_chk = 0, n_err = 0;
  mem_wb_hilo #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .hi_o(hi_o), .lo_o(lo_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("wb_wd", 64'(wb_wd), 64'(m.wd));
    chk("wb_wreg", 64'(wb_wreg), 64'(m.wreg));
    chk("wb_wdata", 64'(wb_wdata), 64'(m.wdata));
    chk("wb_hilo", {wb_hi, wb_lo}, {m.hi, m.lo});
    chk("wb_whilo", 64'(wb_whilo), 64'(m.whilo));
    chk("arch_hilo", {dut.u_hilo.hi_q, dut.u_hilo.lo_q}, {a_hi, a_lo});
    chk("fwd_hilo", {hi_o, lo_o},
        mem_whilo ? {mem_hi, mem_lo} : m.whilo ? {m.hi, m.lo} : {a_hi, a_lo});
  endtask
  task automatic clear_model();
    m = '{default: 0};
    a_hi = '0;
    a_lo = '0;
  endtask
  // Inputs are set just after a falling edge; one call covers one rising edge.
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    if (!rst) clear_model();
    else begin
      if (m.whilo && !stall[5]) begin
        a_hi = m.hi;
        a_lo = m.lo;
      end
      if (flush || (stall[4] && !stall[5])) m = '{default: 0};
      else if (!stall[5]) m = '{mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo};
    end
    @(negedge clk);
  endtask
  task automatic idle_inputs();
    stall = '0; flush = 0; mem_wd = '0; mem_wreg = 0; mem_wdata = '0;
    mem_hi = '0; mem_lo = '0; mem_whilo = 0;
  endtask
  task automatic set_hilo(input logic [DW-1:0] h, input logic [DW-1:0] l);
    mem_whilo = 1; mem_hi = h; mem_lo = l;
  endtask
  task automatic async_reset();
    mem_wd = 5'd9; mem_wreg = 1; mem_wdata = 32'h1234; set_hilo(32'h55, 32'h66);
    #2 rst = 0;
    #1 chk("rst_wreg", 64'(wb_wreg), 64'd0);
    chk("rst_wdata", 64'(wb_wdata), 64'd0);
    chk("rst_whilo", 64'(wb_whilo), 64'd0);
    chk("rst_arch", {dut.u_hilo.hi_q, dut.u_hilo.lo_q}, 64'd0);
    clear_model();
    @(negedge clk);
    mem_whilo = 0;
    #1 chk("rst_hi_o", {hi_o, lo_o}, 64'd0);
    cycle();
    rst = 1;
    idle_inputs();
  endtask
  initial begin
    clear_model();
    @(negedge clk);
    cycle();
    rst = 1;
    cycle();
    mem_wd = 5'd5; mem_wreg = 1; mem_wdata = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    chk("norm_wdata", 64'(wb_wdata), 64'hDEADBEEF);
    chk("norm_wd", 64'(wb_wd), 64'd5);
    set_hilo(32'h11, 32'h22);
    #1 chk("byp_mem", 64'(hi_o), 64'h11);
    cycle();
    idle_inputs();
    chk("byp_wb", {64'(wb_whilo), 64'(hi_o)}, {64'd1, 64'h11});
    cycle();
    chk("commit", {dut.u_hilo.hi_q, dut.u_hilo.lo_q}, {32'h11, 32'h22});
    chk("arch_rd", {64'(wb_whilo), 64'(hi_o)}, {64'd0, 64'h11});
    set_hilo(32'h1, 32'h0);
    cycle();
    set_hilo(32'h2, 32'h0);
    #1 chk("prio_mem", 64'(hi_o), 64'h2);
    cycle();
    chk("prio_arch", 64'(dut.u_hilo.hi_q), 64'h1);
    chk("prio_wb", 64'(wb_hi), 64'h2);
    stall = 6'b010000; mem_wreg = 1; set_hilo(32'h3, 32'h3);
    cycle();
    chk("stall_bubble", {64'(wb_wreg), 64'(wb_whilo)}, 64'd0);
    chk("stall_arch", 64'(dut.u_hilo.hi_q), 64'h2);
    stall = 6'b000000; set_hilo(32'h4, 32'h4);
    cycle();
    stall = 6'b110000; set_hilo(32'h7, 32'h7);
    repeat (3) cycle();
    chk("hold_arch", 64'(dut.u_hilo.hi_q), 64'h2);
    chk("hold_wb", 64'(wb_hi), 64'h4);
    stall = 6'b000000; flush = 1; mem_wreg = 1; mem_whilo = 0;
    cycle();
    chk("flush_wreg", 64'(wb_wreg), 64'd0);
    chk("flush_commit", 64'(dut.u_hilo.hi_q), 64'h4);
    idle_inputs();
    cycle();
    async_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(59) == 0) async_reset();
      case ($urandom_range(3))
        1: stall = {2'b01, 4'($urandom)};
        2: stall = {2'b11, 4'($urandom)};
        default: stall = {2'b00, 4'($urandom)};
      endcase
      flush = ($urandom_range(7) == 0);
      mem_wd = AW'($urandom);
      mem_wreg = 1'($urandom);
      mem_wdata = $urandom;
      mem_hi = $urandom;
      mem_lo = $urandom;
      mem_whilo = 1'($urandom);
      cycle();
    end
    idle_inputs();
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
